vga_text_fetch_arbiter: RTL



---
 rtl/vga_text_fetch_arbiter_if.sv | 12 +
 rtl/vga_text_fetch_arbiter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/vga_text_fetch_arbiter_if.sv
// vga_text_fetch_arbiter_if: CPU request/ack bus into the video RAM arbiter.
// The requester holds req and its fields stable until ack.
interface vga_text_fetch_arbiter_if;
   logic        req;
   logic        we;
   logic [15:0] addr;
   logic [15:0] wdata;
   logic        ack;
   logic [15:0] rdata;
   modport master (output req, we, addr, wdata, input ack, rdata);
   modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/vga_text_fetch_arbiter.sv
// vga_text_fetch_arbiter: shares the video RAM between the CPU bus and the text-mode glyph fetcher.
// Defining VGA_STALL_STATS_EN adds the cpu_stall_cnt output.
module vga_text_fetch_arbiter #(
   parameter logic [9:0]  H_DISPLAY_START = 10'd144,
   parameter logic [9:0]  V_DISPLAY_START = 10'd33,
   parameter int          TILES_PER_ROW   = 80,
   parameter logic [15:0] TILE_BASE       = 16'h8000,
   parameter logic [15:0] GLYPH_BASE      = 16'hC000
) (
   input  logic                    clk,
   input  logic                    clr,
   input  logic                    pix_en,
   input  logic [9:0]              column_internal,
   input  logic [9:0]              row_internal,
   vga_text_fetch_arbiter_if.slave cpu,
   output logic [15:0]             mem_addr,
   output logic                    mem_we,
   output logic [15:0]             mem_wdata,
   input  logic [15:0]             mem_rdata,
   output logic [7:0]              glyph_row,
   output logic [7:0]              glyph_attr,
   output logic                    glyph_valid,
`ifdef VGA_STALL_STATS_EN
   output logic [15:0]             cpu_stall_cnt,
`endif
   output logic                    underrun
);
   localparam logic [6:0] TILES = 7'(TILES_PER_ROW);
   typedef enum logic [2:0] {IDLE, V_TILE, V_GLYPH, V_DONE, C_ACC, C_ACK} state_t;
   state_t      state, state_nxt;
   logic [9:0]  rel_row, rel_col;
   logic [6:0]  k;
   logic        disp_row, on_grid, fetch_trig, promote, line_end;
   logic        vid_pending, staged_valid;
   logic [15:0] tile_addr;
   logic [2:0]  line;
   logic [7:0]  attr, staged_glyph, staged_attr;
   assign rel_row    = row_internal - V_DISPLAY_START;
   assign rel_col    = column_internal - (H_DISPLAY_START - 10'd8);
   assign k          = rel_col[9:3];
   assign disp_row   = row_internal >= V_DISPLAY_START && row_internal < V_DISPLAY_START + 10'd480;
   assign on_grid    = disp_row && pix_en && column_internal >= H_DISPLAY_START - 10'd8 &&
                       rel_col[2:0] == 3'd0 && k <= TILES;
   assign fetch_trig = on_grid && k < TILES;
   assign promote    = on_grid && k != 7'd0;
   assign line_end   = pix_en && column_internal == H_DISPLAY_START + 10'd640;
   always_ff @(posedge clk) state <= clr ? IDLE : state_nxt;
   always_comb begin
      state_nxt = IDLE;
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      cpu.ack   = 1'b0;
      cpu.rdata = '0;
      case (state)
         // V_DONE dispatches like IDLE, so a CPU access behind a fetch waits only the 3 video cycles
         IDLE, V_DONE: state_nxt = (vid_pending || fetch_trig) ? V_TILE : cpu.req ? C_ACC : IDLE;
         V_TILE: begin
            mem_addr  = tile_addr;
            state_nxt = V_GLYPH;
         end
         V_GLYPH: begin
            mem_addr  = GLYPH_BASE + {5'b0, mem_rdata[7:0], 3'b000} + {13'b0, line};
            state_nxt = V_DONE;
         end
         C_ACC: begin
            mem_addr  = cpu.addr;
            mem_we    = cpu.we;
            mem_wdata = cpu.wdata;
            state_nxt = C_ACK;
         end
         C_ACK: begin
            cpu.ack   = 1'b1;
            cpu.rdata = mem_rdata;
         end
         default: ;
      endcase
   end
   always_ff @(posedge clk) begin
      if (clr) begin
         vid_pending  <= 1'b0;
         staged_valid <= 1'b0;
         tile_addr    <= '0;
         line         <= '0;
         attr         <= '0;
         staged_glyph <= '0;
         staged_attr  <= '0;
         glyph_row    <= '0;
         glyph_attr   <= '0;
         glyph_valid  <= 1'b0;
         underrun     <= 1'b0;
      end else begin
         if (state == V_TILE) vid_pending <= 1'b0;
         if (fetch_trig) begin
            vid_pending <= 1'b1;
            tile_addr   <= TILE_BASE + {3'b0, rel_row[9:3], 6'b0} + {5'b0, rel_row[9:3], 4'b0} + {9'b0, k};
            line        <= rel_row[2:0];
         end
         if (state == V_GLYPH) attr <= mem_rdata[15:8];
         if (promote) begin
            glyph_row    <= staged_valid ? staged_glyph : 8'h00;
            glyph_attr   <= staged_valid ? staged_attr : glyph_attr;
            glyph_valid  <= staged_valid;
            underrun     <= underrun | ~staged_valid;
            staged_valid <= 1'b0;
         end else if (line_end) glyph_valid <= 1'b0;
         // a fetch completing on a promotion edge is staged for the following tile
         if (state == V_DONE) begin
            staged_glyph <= mem_rdata[7:0];
            staged_attr  <= attr;
            staged_valid <= 1'b1;
         end
      end
   end
`ifdef VGA_STALL_STATS_EN
   always_ff @(posedge clk)
      if (clr) cpu_stall_cnt <= '0;
      else if (cpu.req && !cpu.ack && cpu_stall_cnt != 16'hFFFF) cpu_stall_cnt <= cpu_stall_cnt + 16'd1;
`endif
endmodule
